shuffle_sequencer: RTL and testbench

SHUFFLE_SEQUENCER -- requirements
Module: shuffle_sequencer

---
 rtl/shuffle_pkg.sv | 49 ++++
 rtl/lfsr16.sv | 26 ++
 rtl/shuffle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_shuffle_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_pkg.sv
// Shared encodings for the 8-puzzle shuffle sequencer: move directions, FSM states,
// LFSR feedback mask, PICK retry limit and the board-geometry legality helper.
package shuffle_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Galois right-shift mask for taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [2:0]  PICK_RETRY_LIMIT = 3'd5;

    function automatic logic [1:0] col_of(input logic [3:0] pos);
        logic [1:0] col;
        case (pos)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
        return col;
    endfunction

    // Reverse pairs differ only in bit 0 (up/down, left/right)
    function automatic logic dir_legal(input dir_e dir, input logic [3:0] pos,
                                       input dir_e last_dir, input logic last_valid);
        logic ok;
        case (dir)
            DIR_UP:    ok = (pos >= 4'd3);
            DIR_DOWN:  ok = (pos <= 4'd5);
            DIR_LEFT:  ok = (col_of(pos) != 2'd0);
            DIR_RIGHT: ok = (col_of(pos) != 2'd2);
            default:   ok = 1'b0;
        endcase
        ok = ok & ~(last_valid & (dir == dir_e'(last_dir ^ 2'b01)));
        return ok;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset and steps every cycle.
module lfsr16
    import shuffle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_r;

    // Shift right, folding the tap mask in when the outgoing bit is set
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= seed;
        end else if (q_r[0]) begin
            q_r <= {1'b0, q_r[15:1]} ^ LFSR_TAPS;
        end else begin
            q_r <= {1'b0, q_r[15:1]};
        end
    end

    assign q = q_r;

endmodule

// File: rtl/shuffle_sequencer.sv
// Issues a burst of random, legal, non-reversing blank-tile moves to the 8-puzzle
// game controller whenever the start level rises.
module shuffle_sequencer
    import shuffle_pkg::*;
#(
    parameter int          SHUFFLE_MOVES = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] blank_pos,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [5:0] moves_left
);

    localparam logic [5:0] MOVES_INIT = 6'(SHUFFLE_MOVES);

    state_e      state_r;
    logic        start_q_r;
    logic [2:0]  pick_cnt_r;
    dir_e        last_dir_r;
    logic        last_valid_r;
    logic        move_valid_r;
    dir_e        move_dir_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [5:0]  moves_left_r;

    logic [15:0] lfsr_q_s;
    logic        unused_lfsr_s;
    logic        start_edge_s;
    dir_e        cand_s;
    logic        cand_ok_s;
    logic        pos_bad_s;
    dir_e        fallback_dir_s;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q_s)
    );

    // Only the two low LFSR bits feed the candidate direction
    assign unused_lfsr_s = ^lfsr_q_s[15:2];
    assign start_edge_s  = start & ~start_q_r;
    assign cand_s        = dir_e'(lfsr_q_s[1:0]);
    assign cand_ok_s     = dir_legal(cand_s, blank_pos, last_dir_r, last_valid_r);
    assign pos_bad_s     = (blank_pos > 4'd8);

    // First legal direction in fixed priority order, used when random picks keep failing
    always_comb begin
        fallback_dir_s = DIR_RIGHT;
        if (dir_legal(DIR_UP, blank_pos, last_dir_r, last_valid_r)) begin
            fallback_dir_s = DIR_UP;
        end else if (dir_legal(DIR_DOWN, blank_pos, last_dir_r, last_valid_r)) begin
            fallback_dir_s = DIR_DOWN;
        end else if (dir_legal(DIR_LEFT, blank_pos, last_dir_r, last_valid_r)) begin
            fallback_dir_s = DIR_LEFT;
        end else begin
            fallback_dir_s = DIR_RIGHT;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            start_q_r    <= 1'b0;
            pick_cnt_r   <= 3'd0;
            last_dir_r   <= DIR_UP;
            last_valid_r <= 1'b0;
            move_valid_r <= 1'b0;
            move_dir_r   <= DIR_UP;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            moves_left_r <= 6'd0;
        end else begin
            start_q_r <= start;
            case (state_r)
                ST_IDLE: begin
                    done_r       <= 1'b0;
                    move_valid_r <= 1'b0;
                    if (start_edge_s) begin
                        moves_left_r <= MOVES_INIT;
                        err_r        <= 1'b0;
                        last_valid_r <= 1'b0;
                        pick_cnt_r   <= 3'd0;
                        busy_r       <= 1'b1;
                        if (MOVES_INIT == 6'd0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_PICK;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_PICK: begin
                    if (abort) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (pos_bad_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (pick_cnt_r == PICK_RETRY_LIMIT - 3'd1) begin
                        move_dir_r   <= fallback_dir_s;
                        move_valid_r <= 1'b1;
                        pick_cnt_r   <= 3'd0;
                        state_r      <= ST_ISSUE;
                    end else if (cand_ok_s) begin
                        move_dir_r   <= cand_s;
                        move_valid_r <= 1'b1;
                        pick_cnt_r   <= 3'd0;
                        state_r      <= ST_ISSUE;
                    end else begin
                        pick_cnt_r <= pick_cnt_r + 3'd1;
                    end
                end
                ST_ISSUE: begin
                    if (move_ready) begin
                        moves_left_r <= moves_left_r - 6'd1;
                        last_dir_r   <= move_dir_r;
                        last_valid_r <= 1'b1;
                        move_valid_r <= 1'b0;
                        state_r      <= ST_SETTLE;
                    end else begin
                        move_valid_r <= 1'b1;
                    end
                    // A simultaneous transfer above still counts; abort only redirects
                    if (abort) begin
                        move_valid_r <= 1'b0;
                        state_r      <= ST_DONE;
                        done_r       <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort || (moves_left_r == 6'd0)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        pick_cnt_r <= 3'd0;
                        state_r    <= ST_PICK;
                    end
                end
                ST_DONE: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    move_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    move_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_valid = move_valid_r;
    assign move_dir   = move_dir_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign moves_left = moves_left_r;

endmodule

// File: tb/tb_shuffle_sequencer.sv
// Directed bench for shuffle_sequencer: full shuffle with board model, stall, abort,
// illegal position, PICK fallback, zero-move shuffle and mid-shuffle reset.
module tb_shuffle_sequencer;

    logic       clk;
    logic       rst, start, abort, move_ready, move_valid, busy, done, err;
    logic [3:0] blank_pos;
    logic [1:0] move_dir;
    logic [5:0] moves_left;

    logic       rst2, start2;
    logic       fb_valid, fb_busy, fb_done, fb_err;
    logic [1:0] fb_dir;
    logic [5:0] fb_left;
    logic       z_valid, z_busy, z_done, z_err;
    logic [1:0] z_dir;
    logic [5:0] z_left;

    int n_vec = 0;
    int n_mis = 0;

    shuffle_sequencer #(.SHUFFLE_MOVES(32), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .blank_pos(blank_pos),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .busy(busy), .done(done), .err(err), .moves_left(moves_left)
    );

    // Seed 16'h8000 keeps lfsr[1:0] at up/left for the first 14 steps
    shuffle_sequencer #(.SHUFFLE_MOVES(32), .LFSR_SEED(16'h8000)) dut_fb (
        .clk(clk), .rst(rst2), .start(start2), .abort(1'b0), .blank_pos(4'd0),
        .move_valid(fb_valid), .move_dir(fb_dir), .move_ready(1'b0),
        .busy(fb_busy), .done(fb_done), .err(fb_err), .moves_left(fb_left)
    );

    shuffle_sequencer #(.SHUFFLE_MOVES(0), .LFSR_SEED(16'hACE1)) dut_z (
        .clk(clk), .rst(rst2), .start(start2), .abort(1'b0), .blank_pos(4'd4),
        .move_valid(z_valid), .move_dir(z_dir), .move_ready(1'b0),
        .busy(z_busy), .done(z_done), .err(z_err), .moves_left(z_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit geo_legal(input logic [1:0] dir, input logic [3:0] pos);
        int p;
        p = int'(pos);
        case (dir)
            2'b00:   return p >= 3;
            2'b01:   return p <= 5;
            2'b10:   return (p % 3) != 0;
            default: return (p % 3) != 2;
        endcase
    endfunction

    function automatic logic [3:0] step_pos(input logic [1:0] dir, input logic [3:0] pos);
        case (dir)
            2'b00:   return pos - 4'd3;
            2'b01:   return pos + 4'd3;
            2'b10:   return pos - 4'd1;
            default: return pos + 4'd1;
        endcase
    endfunction

    initial begin
        int xfers, bad, revs, done_cnt, done_cyc, last_x, busy_after;
        int pick_cnt, z_busy_cnt, z_done_cnt, z_mv_cnt, mv_cnt;
        bit prev_valid, fb_seen;
        logic [1:0] prev_dir, dir0, fb_dir0;

        rst = 1'b1; start = 1'b0; abort = 1'b0; move_ready = 1'b1; blank_pos = 4'd4;
        rst2 = 1'b1; start2 = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 16'(move_valid), 16'd0);
        check_val("rst_busy", 16'(busy), 16'd0);
        check_val("rst_done", 16'(done), 16'd0);
        check_val("rst_err", 16'(err), 16'd0);
        check_val("rst_left", 16'(moves_left), 16'd0);
        check_val("rst_dir", 16'(move_dir), 16'd0);

        // Fallback at a corner plus zero-move shuffle, sharing rst2/start2
        rst2 = 1'b0; start2 = 1'b1;
        pick_cnt = 0; fb_seen = 1'b0; fb_dir0 = 2'b11;
        z_busy_cnt = 0; z_done_cnt = 0; z_mv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!fb_seen && fb_valid) begin
                fb_seen = 1'b1;
                fb_dir0 = fb_dir;
            end else if (!fb_seen && fb_busy) begin
                pick_cnt++;
            end
            if (z_busy) z_busy_cnt++;
            if (z_done) z_done_cnt++;
            if (z_valid) z_mv_cnt++;
        end
        check_val("fb_issued", 16'(fb_seen), 16'd1);
        check_val("fb_dir_down", 16'(fb_dir0), 16'd1);
        check_val("fb_pick_cycles", 16'(pick_cnt), 16'd5);
        check_val("zero_busy_cycles", 16'(z_busy_cnt), 16'd1);
        check_val("zero_done", 16'(z_done_cnt), 16'd1);
        check_val("zero_no_move", 16'(z_mv_cnt), 16'd0);

        // Reset while stalled in ISSUE: no done pulse, no further moves
        rst2 = 1'b1; start2 = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", 16'(fb_valid), 16'd0);
        check_val("mid_rst_busy", 16'(fb_busy), 16'd0);
        rst2 = 1'b0;
        done_cnt = 0; mv_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (fb_done) done_cnt++;
            if (fb_valid) mv_cnt++;
        end
        check_val("mid_rst_no_done", 16'(done_cnt + mv_cnt), 16'd0);

        // Full 32-move shuffle against the board model
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        prev_valid = 1'b0; prev_dir = 2'b00;
        xfers = 0; bad = 0; revs = 0; done_cnt = 0; done_cyc = -1; last_x = -100; busy_after = 1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (move_valid && move_ready) begin
                if (!geo_legal(move_dir, blank_pos)) bad++;
                if (prev_valid && (move_dir == (prev_dir ^ 2'b01))) revs++;
                prev_dir = move_dir; prev_valid = 1'b1;
                blank_pos = step_pos(move_dir, blank_pos);
                xfers++; last_x = cyc;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
            end else if (done_cnt > 0) begin
                busy_after = int'(busy);
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_val("main_xfers", 16'(xfers), 16'd32);
        check_val("main_illegal", 16'(bad), 16'd0);
        check_val("main_reversal", 16'(revs), 16'd0);
        check_val("main_done_once", 16'(done_cnt), 16'd1);
        check_val("main_done_timing", 16'(done_cyc), 16'(last_x + 2));
        check_val("main_busy_fall", 16'(busy_after), 16'd0);
        check_val("main_left_zero", 16'(moves_left), 16'd0);

        // Stall ISSUE for 10 cycles
        start = 1'b0; move_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_valid) break;
        end
        dir0 = move_dir;
        check_val("stall_valid0", 16'(move_valid), 16'd1);
        check_val("stall_left0", 16'(moves_left), 16'd32);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("stall_valid", 16'(move_valid), 16'd1);
            check_val("stall_dir", 16'(move_dir), 16'(dir0));
        end
        move_ready = 1'b1;
        blank_pos = step_pos(move_dir, blank_pos);
        @(negedge clk);
        check_val("stall_after_valid", 16'(move_valid), 16'd0);
        check_val("stall_left", 16'(moves_left), 16'd31);

        // Run down to 20 moves left, then abort together with the transfer
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (move_valid) begin
                blank_pos = step_pos(move_dir, blank_pos);
                if (moves_left == 6'd20) begin
                    abort = 1'b1;
                    break;
                end
            end
        end
        @(negedge clk);
        abort = 1'b0; start = 1'b1;
        check_val("abort_left", 16'(moves_left), 16'd19);
        check_val("abort_done", 16'(done), 16'd1);
        check_val("abort_valid", 16'(move_valid), 16'd0);
        @(negedge clk);
        check_val("abort_idle_busy", 16'(busy), 16'd0);
        check_val("abort_idle_done", 16'(done), 16'd0);
        @(negedge clk);
        check_val("busy_start_ignored", 16'(busy), 16'd0);
        check_val("abort_no_valid", 16'(move_valid), 16'd0);

        // Out-of-range blank position at the first PICK
        blank_pos = 4'd9; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        done_cnt = 0; mv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (move_valid) mv_cnt++;
        end
        check_val("err_set", 16'(err), 16'd1);
        check_val("err_done", 16'(done_cnt), 16'd1);
        check_val("err_no_xfer", 16'(mv_cnt), 16'd0);
        blank_pos = 4'd4; start = 1'b0; move_ready = 1'b0;
        @(negedge clk);
        check_val("err_sticky", 16'(err), 16'd1);
        start = 1'b1;
        @(negedge clk);
        check_val("err_cleared", 16'(err), 16'd0);
        check_val("restart_busy", 16'(busy), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
